// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one WB read or
// write cycle out (with bus timeout), one response back.
module wb_cmd_master #(
  parameter int TIMEOUT = 256,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rstn,
  // Handshakes: a beat transfers on a rising clk edge where valid && ready.
  // cmd_ready is high only in IDLE; resp_valid, once raised, stays high with
  // resp_dat/resp_status frozen until the edge that sees resp_ready.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_dat,
  output logic [1:0]  resp_status,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rtry_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0]    ST_OK      = 2'b00;
  localparam logic [1:0]    ST_ERR     = 2'b01;
  localparam logic [1:0]    ST_RTRY    = 2'b10;
  localparam logic [1:0]    ST_TIMEOUT = 2'b11;
  localparam logic [TW-1:0] CNT_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_ONE    = TW'(1);

  state_e        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [1:0]    rstat_q, rstat_d;
  logic          term;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdat_d   = rdat_q;
    rstat_d  = rstat_q;
    term     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        // Slave responses win over the timeout, even on the last counted cycle.
        if (wb_ack_i) begin
          term    = 1'b1;
          rstat_d = ST_OK;
          rdat_d  = we_q ? 32'h0 : wb_dat_i;
        end else if (wb_err_i) begin
          term    = 1'b1;
          rstat_d = ST_ERR;
          rdat_d  = 32'h0;
        end else if (wb_rtry_i) begin
          term    = 1'b1;
          rstat_d = ST_RTRY;
          rdat_d  = 32'h0;
        end else if (cnt_q == CNT_LAST) begin
          term    = 1'b1;
          rstat_d = ST_TIMEOUT;
          rdat_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end

        if (term) begin
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        cyc_d    = 1'b0;
        rvalid_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdat_q   <= '0;
      rstat_q  <= ST_OK;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdat_q   <= rdat_d;
      rstat_q  <= rstat_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign resp_valid  = rvalid_q;
  assign resp_dat    = rdat_q;
  assign resp_status = rstat_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;
  assign dbg_state_o = state_q;

endmodule
